// File: rtl/regfile_write_arbiter_if.sv
// Bundle of writeback request channels, issue/read-check inputs and register-file write outputs.
// The arbiter takes the slave side; requesters and the issue stage take the master side.
interface regfile_write_arbiter_if #(
  parameter int unsigned WORD = 16,
  parameter int unsigned ADDR = 6,
  parameter int unsigned NREG = 7
);
  logic            alu_valid;
  logic            alu_ready;
  logic [ADDR-1:0] alu_addr;
  logic [WORD-1:0] alu_data;

  logic            ld_valid;
  logic            ld_ready;
  logic [ADDR-1:0] ld_addr;
  logic [WORD-1:0] ld_data;

  logic            dbg_valid;
  logic            dbg_ready;
  logic [ADDR-1:0] dbg_addr;
  logic [WORD-1:0] dbg_data;

  logic            iss_valid;
  logic [ADDR-1:0] iss_dest;
  logic [ADDR-1:0] rs1_addr;
  logic [ADDR-1:0] rs2_addr;
  logic            hazard;
  logic [NREG-1:0] busy;

  logic            rf_we;
  logic [ADDR-1:0] rf_waddr;
  logic [WORD-1:0] rf_wdata;
  logic            err_pc_write;

  modport master (
    output alu_valid, alu_addr, alu_data,
    input  alu_ready,
    output ld_valid, ld_addr, ld_data,
    input  ld_ready,
    output dbg_valid, dbg_addr, dbg_data,
    input  dbg_ready,
    output iss_valid, iss_dest, rs1_addr, rs2_addr,
    input  hazard, busy,
    input  rf_we, rf_waddr, rf_wdata, err_pc_write
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    output alu_ready,
    input  ld_valid, ld_addr, ld_data,
    output ld_ready,
    input  dbg_valid, dbg_addr, dbg_data,
    output dbg_ready,
    input  iss_valid, iss_dest, rs1_addr, rs2_addr,
    output hazard, busy,
    output rf_we, rf_waddr, rf_wdata, err_pc_write
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register file's single write port (ALU, load, debug),
// with PC/out-of-range write blocking and a per-register RAW busy scoreboard.
module regfile_write_arbiter #(
  parameter int unsigned WORD    = 16,
  parameter int unsigned ADDR    = 6,
  parameter int unsigned NREG    = 7,
  parameter int unsigned PC_ADDR = 6
) (
  input logic                     clk,
  input logic                     Reset,
  regfile_write_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {PtrAlu, PtrLd, PtrDbg} ptr_e;

  ptr_e            ptr_q, ptr_d;
  logic [2:0]      req, gnt;
  logic            xfer, sel_legal, iss_legal, hazard;
  logic [ADDR-1:0] sel_addr;
  logic [WORD-1:0] sel_data;
  logic [NREG-1:0] busy_q, busy_d;
  logic            rf_we_q, err_q;
  logic [ADDR-1:0] rf_waddr_q;
  logic [WORD-1:0] rf_wdata_q;

  function automatic logic is_legal(logic [ADDR-1:0] a);
    return (a != ADDR'(PC_ADDR)) && (32'(a) < NREG);
  endfunction

  assign req = {bus.dbg_valid, bus.ld_valid, bus.alu_valid};

  // Search order starts at the pointer and wraps ALU -> LD -> DBG -> ALU.
  always_comb begin
    gnt = 3'b000;
    if (!Reset) begin
      unique case (ptr_q)
        PtrLd: begin
          if (req[1])      gnt = 3'b010;
          else if (req[2]) gnt = 3'b100;
          else if (req[0]) gnt = 3'b001;
        end
        PtrDbg: begin
          if (req[2])      gnt = 3'b100;
          else if (req[0]) gnt = 3'b001;
          else if (req[1]) gnt = 3'b010;
        end
        default: begin
          if (req[0])      gnt = 3'b001;
          else if (req[1]) gnt = 3'b010;
          else if (req[2]) gnt = 3'b100;
        end
      endcase
    end
  end

  assign bus.alu_ready = gnt[0];
  assign bus.ld_ready  = gnt[1];
  assign bus.dbg_ready = gnt[2];
  assign xfer          = |gnt;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    ptr_d    = ptr_q;
    unique case (gnt)
      3'b001: begin
        sel_addr = bus.alu_addr;
        sel_data = bus.alu_data;
        ptr_d    = PtrLd;
      end
      3'b010: begin
        sel_addr = bus.ld_addr;
        sel_data = bus.ld_data;
        ptr_d    = PtrDbg;
      end
      3'b100: begin
        sel_addr = bus.dbg_addr;
        sel_data = bus.dbg_data;
        ptr_d    = PtrAlu;
      end
      default: ;
    endcase
  end

  assign sel_legal = is_legal(sel_addr);
  assign iss_legal = is_legal(bus.iss_dest);

  // Set is applied after clear so a same-edge issue keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (xfer && sel_legal && (sel_addr == ADDR'(i))) busy_d[i] = 1'b0;
      if (bus.iss_valid && iss_legal && (bus.iss_dest == ADDR'(i))) busy_d[i] = 1'b1;
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if ((i != PC_ADDR) && busy_q[i] &&
          ((bus.rs1_addr == ADDR'(i)) || (bus.rs2_addr == ADDR'(i)))) begin
        hazard = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      ptr_q      <= PtrAlu;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      err_q      <= 1'b0;
      busy_q     <= '0;
    end else begin
      rf_we_q <= xfer && sel_legal;
      err_q   <= xfer && !sel_legal;
      if (xfer && sel_legal) begin
        rf_waddr_q <= sel_addr;
        rf_wdata_q <= sel_data;
      end
      if (xfer) ptr_q <= ptr_d;
      busy_q <= busy_d;
    end
  end

  assign bus.hazard       = hazard;
  assign bus.busy         = busy_q;
  assign bus.rf_we        = rf_we_q;
  assign bus.rf_waddr     = rf_waddr_q;
  assign bus.rf_wdata     = rf_wdata_q;
  assign bus.err_pc_write = err_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed scenarios plus randomized traffic checked against a queue-free behavioural model.
module tb_regfile_write_arbiter;
  logic clk = 1'b0;
  logic Reset = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.WORD(16), .ADDR(6), .NREG(7)) bus ();

  regfile_write_arbiter #(.WORD(16), .ADDR(6), .NREG(7), .PC_ADDR(6)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic bit legal(int x);
    return (x >= 0) && (x < 7) && (x != 6);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.alu_valid = 0; bus.alu_addr = 0; bus.alu_data = 0;
    bus.ld_valid  = 0; bus.ld_addr  = 0; bus.ld_data  = 0;
    bus.dbg_valid = 0; bus.dbg_addr = 0; bus.dbg_data = 0;
    bus.iss_valid = 0; bus.iss_dest = 0;
    bus.rs1_addr  = 0; bus.rs2_addr = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    Reset = 1;
    tick();
    tick();
    Reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.rf_we, bus.err_pc_write} !== 2'b00) begin
      errors++; $display("FAIL reset_we_err got %b want 00", {bus.rf_we, bus.err_pc_write});
    end
    checks++;
    if ({bus.rf_waddr, bus.rf_wdata} !== 22'h0) begin
      errors++; $display("FAIL reset_addr_data got %0h want 0", {bus.rf_waddr, bus.rf_wdata});
    end
    checks++;
    if (bus.busy !== 7'h0) begin
      errors++; $display("FAIL reset_busy got %0h want 0", bus.busy);
    end
  endtask

  task automatic test_single_write();
    bus.alu_valid = 1; bus.alu_addr = 3; bus.alu_data = 16'h1234;
    #1;
    checks++;
    if ({bus.dbg_ready, bus.ld_ready, bus.alu_ready} !== 3'b001) begin
      errors++; $display("FAIL single_ready got %b want 001",
                         {bus.dbg_ready, bus.ld_ready, bus.alu_ready});
    end
    tick();
    bus.alu_valid = 0;
    checks++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 6'd3, 16'h1234}) begin
      errors++; $display("FAIL single_write got we=%b a=%0d d=%h want we=1 a=3 d=1234",
                         bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    end
  endtask

  task automatic test_round_robin();
    logic [5:0] addrs [3];
    addrs[0] = 1; addrs[1] = 2; addrs[2] = 4;
    do_reset();
    bus.alu_valid = 1; bus.alu_addr = 1; bus.alu_data = 16'hA001;
    bus.ld_valid  = 1; bus.ld_addr  = 2; bus.ld_data  = 16'hB002;
    bus.dbg_valid = 1; bus.dbg_addr = 4; bus.dbg_data = 16'hC004;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++;
      if ({bus.dbg_ready, bus.ld_ready, bus.alu_ready} !== 3'(1 << (c % 3))) begin
        errors++; $display("FAIL rr_ready c=%0d got %b want %b", c,
                           {bus.dbg_ready, bus.ld_ready, bus.alu_ready}, 3'(1 << (c % 3)));
      end
      if (c > 0) begin
        checks++;
        if ({bus.rf_we, bus.rf_waddr} !== {1'b1, addrs[(c - 1) % 3]}) begin
          errors++; $display("FAIL rr_write c=%0d got we=%b a=%0d want we=1 a=%0d", c,
                             bus.rf_we, bus.rf_waddr, addrs[(c - 1) % 3]);
        end
      end
      tick();
    end
    clear_inputs();
    #1;
    checks++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 6'd4, 16'hC004}) begin
      errors++; $display("FAIL rr_last got we=%b a=%0d d=%h want we=1 a=4 d=c004",
                         bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    end
    tick();
    checks++;
    if (bus.rf_we !== 1'b0) begin
      errors++; $display("FAIL rr_idle got we=%b want 0", bus.rf_we);
    end
  endtask

  task automatic test_illegal();
    bus.dbg_valid = 1; bus.dbg_addr = 6; bus.dbg_data = 16'hDEAD;
    #1;
    checks++;
    if (bus.dbg_ready !== 1'b1) begin
      errors++; $display("FAIL pc_ready got %b want 1", bus.dbg_ready);
    end
    tick();
    bus.dbg_valid = 0;
    checks++;
    if ({bus.rf_we, bus.err_pc_write} !== 2'b01) begin
      errors++; $display("FAIL pc_err got we/err=%b want 01", {bus.rf_we, bus.err_pc_write});
    end
    tick();
    checks++;
    if (bus.err_pc_write !== 1'b0) begin
      errors++; $display("FAIL pc_err_pulse got %b want 0", bus.err_pc_write);
    end
  endtask

  task automatic test_scoreboard();
    bus.iss_valid = 1; bus.iss_dest = 2;
    tick();
    bus.iss_valid = 0; bus.rs1_addr = 2; bus.rs2_addr = 5;
    #1;
    checks++;
    if ({bus.busy[2], bus.hazard} !== 2'b11) begin
      errors++; $display("FAIL sb_set got busy2/haz=%b want 11", {bus.busy[2], bus.hazard});
    end
    bus.ld_valid = 1; bus.ld_addr = 2; bus.ld_data = 16'h5A5A;
    #1;
    checks++;
    if (bus.ld_ready !== 1'b1) begin
      errors++; $display("FAIL sb_ld_ready got %b want 1", bus.ld_ready);
    end
    tick();
    bus.ld_valid = 0;
    #1;
    checks++;
    if ({bus.rf_we, bus.busy[2], bus.hazard} !== 3'b100) begin
      errors++; $display("FAIL sb_clear got we/busy2/haz=%b want 100",
                         {bus.rf_we, bus.busy[2], bus.hazard});
    end
  endtask

  task automatic test_set_wins();
    bus.alu_valid = 1; bus.alu_addr = 4; bus.alu_data = 16'h0444;
    bus.iss_valid = 1; bus.iss_dest = 4;
    tick();
    clear_inputs();
    checks++;
    if ({bus.rf_we, bus.rf_waddr, bus.busy[4]} !== {1'b1, 6'd4, 1'b1}) begin
      errors++; $display("FAIL setwins got we=%b a=%0d busy4=%b want 1 4 1",
                         bus.rf_we, bus.rf_waddr, bus.busy[4]);
    end
    bus.ld_valid = 1; bus.ld_addr = 4; bus.ld_data = 16'h0555;
    tick();
    clear_inputs();
    checks++;
    if (bus.busy[4] !== 1'b0) begin
      errors++; $display("FAIL setwins_clear got %b want 0", bus.busy[4]);
    end
  endtask

  task automatic test_reset_inflight();
    bus.iss_valid = 1; bus.iss_dest = 3;
    tick();
    bus.iss_valid = 0;
    bus.alu_valid = 1; bus.alu_addr = 5; bus.alu_data = 16'h7777;
    Reset = 1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (bus.alu_ready !== 1'b0) begin
        errors++; $display("FAIL rst_ready c=%0d got %b want 0", c, bus.alu_ready);
      end
      tick();
      checks++;
      if ({bus.rf_we, bus.busy} !== 8'h00) begin
        errors++; $display("FAIL rst_state c=%0d got we=%b busy=%h want 0 00", c,
                           bus.rf_we, bus.busy);
      end
    end
    Reset = 0;
    #1;
    checks++;
    if (bus.alu_ready !== 1'b1) begin
      errors++; $display("FAIL rst_release_ready got %b want 1", bus.alu_ready);
    end
    tick();
    clear_inputs();
    checks++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 6'd5, 16'h7777}) begin
      errors++; $display("FAIL rst_replay got we=%b a=%0d d=%h want 1 5 7777",
                         bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    end
  endtask

  task automatic test_random();
    int        ptr;
    int        g;
    bit [6:0]  mb;
    bit        e_we, e_err, e_haz;
    int        e_a;
    int        e_d;
    bit        v [3];
    int        a [3];
    int        d [3];
    int        iss, r1, r2;
    bit        iv;
    logic [2:0] e_rdy;
    do_reset();
    ptr = 0; mb = 0; e_we = 0; e_err = 0; e_a = 0; e_d = 0;
    for (int r = 0; r < 3; r++) begin v[r] = 0; a[r] = 0; d[r] = 0; end
    for (int c = 0; c < 500; c++) begin
      checks++;
      if ({bus.rf_we, bus.err_pc_write, bus.busy} !== {e_we, e_err, mb}) begin
        errors++; $display("FAIL rnd_regs c=%0d got we=%b err=%b busy=%h want %b %b %h", c,
                           bus.rf_we, bus.err_pc_write, bus.busy, e_we, e_err, mb);
      end
      if (e_we) begin
        checks++;
        if ({bus.rf_waddr, bus.rf_wdata} !== {6'(e_a), 16'(e_d)}) begin
          errors++; $display("FAIL rnd_data c=%0d got a=%0d d=%h want a=%0d d=%h", c,
                             bus.rf_waddr, bus.rf_wdata, e_a, 16'(e_d));
        end
      end
      // Requesters not yet served keep their request unchanged.
      for (int r = 0; r < 3; r++) begin
        if (!v[r]) begin
          v[r] = ($urandom_range(0, 2) != 0);
          a[r] = $urandom_range(0, 9);
          d[r] = $urandom_range(0, 65535);
        end
      end
      iv  = ($urandom_range(0, 3) == 0);
      iss = $urandom_range(0, 9);
      r1  = $urandom_range(0, 9);
      r2  = $urandom_range(0, 9);
      bus.alu_valid = v[0]; bus.alu_addr = 6'(a[0]); bus.alu_data = 16'(d[0]);
      bus.ld_valid  = v[1]; bus.ld_addr  = 6'(a[1]); bus.ld_data  = 16'(d[1]);
      bus.dbg_valid = v[2]; bus.dbg_addr = 6'(a[2]); bus.dbg_data = 16'(d[2]);
      bus.iss_valid = iv;   bus.iss_dest = 6'(iss);
      bus.rs1_addr  = 6'(r1); bus.rs2_addr = 6'(r2);
      #1;
      g = -1;
      for (int k = 0; k < 3; k++) begin
        if (g < 0 && v[(ptr + k) % 3]) g = (ptr + k) % 3;
      end
      e_rdy = (g >= 0) ? 3'(1 << g) : 3'b000;
      checks++;
      if ({bus.dbg_ready, bus.ld_ready, bus.alu_ready} !== e_rdy) begin
        errors++; $display("FAIL rnd_ready c=%0d got %b want %b", c,
                           {bus.dbg_ready, bus.ld_ready, bus.alu_ready}, e_rdy);
      end
      e_haz = (legal(r1) && mb[r1]) || (legal(r2) && mb[r2]);
      checks++;
      if (bus.hazard !== e_haz) begin
        errors++; $display("FAIL rnd_hazard c=%0d got %b want %b", c, bus.hazard, e_haz);
      end
      e_we = 0; e_err = 0;
      if (g >= 0) begin
        if (legal(a[g])) begin
          e_we = 1; e_a = a[g]; e_d = d[g];
          mb[a[g]] = 0;
        end else begin
          e_err = 1;
        end
        ptr = (g + 1) % 3;
        v[g] = 0;
      end
      if (iv && legal(iss)) mb[iss] = 1;
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_write();
    test_round_robin();
    test_illegal();
    test_scoreboard();
    test_set_wins();
    test_reset_inflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
